// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, imem addressing and the IF/ID pipeline register.
// Optional misaligned-redirect detection is enabled by defining FETCH_ALIGN_CHECK_EN.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [15:0] branch_offset,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic [31:0] redirect_pc_plus4,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc_plus4,
  output logic        ifid_valid
`ifdef FETCH_ALIGN_CHECK_EN
  ,
  output logic        fetch_error
`endif
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_plus4_q, pc_plus4_d;
  logic        valid_q, valid_d;
  logic [31:0] pc_plus4;
  logic [31:0] branch_target;
  logic [31:0] jump_target;
  logic [31:0] target;
  logic        redirect;
  logic        hold_error;

  assign pc_plus4      = pc_q + 32'd4;
  assign branch_target = redirect_pc_plus4 + {{14{branch_offset[15]}}, branch_offset, 2'b00};
  assign jump_target   = {redirect_pc_plus4[31:28], jump_index, 2'b00};
  // Jump outranks a simultaneous taken branch.
  assign target        = jump ? jump_target : branch_target;
  assign redirect      = jump | branch_taken;
  assign imem_addr     = {2'b00, pc_q[31:2]};

`ifdef FETCH_ALIGN_CHECK_EN
  logic error_q, error_d;

  assign hold_error  = error_q;
  assign error_d     = error_q | (redirect & (target[1:0] != 2'b00));
  assign fetch_error = error_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      error_q <= 1'b0;
    end else begin
      error_q <= error_d;
    end
  end
`else
  assign hold_error = 1'b0;
`endif

  always_comb begin
    pc_d       = pc_q;
    instr_d    = instr_q;
    pc_plus4_d = pc_plus4_q;
    valid_d    = valid_q;
    if (hold_error || redirect) begin
      // A redirect beats stall: the stalled IF/ID content is wrong-path.
      if (!hold_error) begin
        pc_d = {target[31:2], 2'b00};
      end
      instr_d    = 32'h0000_0000;
      pc_plus4_d = 32'h0000_0000;
      valid_d    = 1'b0;
    end else if (!stall) begin
      pc_d       = pc_plus4;
      instr_d    = imem_data;
      pc_plus4_d = pc_plus4;
      valid_d    = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_q       <= RESET_PC;
      instr_q    <= 32'h0000_0000;
      pc_plus4_q <= 32'h0000_0000;
      valid_q    <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      pc_plus4_q <= pc_plus4_d;
      valid_q    <= valid_d;
    end
  end

  assign ifid_instr    = instr_q;
  assign ifid_pc_plus4 = pc_plus4_q;
  assign ifid_valid    = valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus random redirect/stall traffic,
// checked against a byte-address reference model of the fetch stage.
module tb_fetch_unit;

  logic        clock;
  logic        reset;
  logic        stall;
  logic        branch_taken;
  logic [15:0] branch_offset;
  logic        jump;
  logic [25:0] jump_index;
  logic [31:0] redirect_pc_plus4;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc_plus4;
  logic        ifid_valid;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        fetch_error;
`endif

  logic [31:0] mem [256];
  assign imem_data = mem[imem_addr[7:0]];

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clock            (clock),
    .reset            (reset),
    .stall            (stall),
    .branch_taken     (branch_taken),
    .branch_offset    (branch_offset),
    .jump             (jump),
    .jump_index       (jump_index),
    .redirect_pc_plus4(redirect_pc_plus4),
    .imem_addr        (imem_addr),
    .imem_data        (imem_data),
    .ifid_instr       (ifid_instr),
    .ifid_pc_plus4    (ifid_pc_plus4),
    .ifid_valid       (ifid_valid)
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    .fetch_error      (fetch_error)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  // Reference model state
  logic [31:0] m_pc, m_instr, m_p4;
  logic        m_valid, m_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_instr = 32'h0; m_p4 = 32'h0; m_valid = 1'b0; m_err = 1'b0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".addr"}, imem_addr, m_pc / 4);
    chk({tag, ".instr"}, ifid_instr, m_instr);
    chk({tag, ".pc4"}, ifid_pc_plus4, m_p4);
    chk({tag, ".valid"}, {31'b0, ifid_valid}, {31'b0, m_valid});
`ifdef FETCH_ALIGN_CHECK_EN
    chk({tag, ".err"}, {31'b0, fetch_error}, {31'b0, m_err});
`endif
  endtask

  // Advance the model by one edge from the current inputs, clock the DUT, compare.
  task automatic step(input string tag);
    logic [31:0] tgt;
    logic signed [31:0] soff;
    soff = 32'(signed'(branch_offset));
    if (jump) tgt = {redirect_pc_plus4[31:28], jump_index, 2'b00};
    else      tgt = redirect_pc_plus4 + soff * 4;
`ifdef FETCH_ALIGN_CHECK_EN
    if (m_err) begin
      m_instr = 0; m_p4 = 0; m_valid = 0;
    end else
`endif
    if (jump || branch_taken) begin
`ifdef FETCH_ALIGN_CHECK_EN
      if (tgt % 4 != 0) m_err = 1'b1;
`endif
      m_pc = tgt - (tgt % 4);
      m_instr = 0; m_p4 = 0; m_valid = 0;
    end else if (!stall) begin
      m_instr = mem[(m_pc / 4) % 256];
      m_pc = m_pc + 4;
      m_p4 = m_pc;
      m_valid = 1'b1;
    end
    @(posedge clock);
    #1;
    check_all(tag);
  endtask

  task automatic idle_inputs();
    stall = 0; branch_taken = 0; jump = 0;
    branch_offset = 0; jump_index = 0; redirect_pc_plus4 = 0;
  endtask

  initial begin
    logic [31:0] r;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[0] = 32'h01098020;
    mem[1] = 32'h01098022;
    mem[2] = 32'h01098024;
    idle_inputs();
    reset = 1'b0;
    model_reset();
    @(posedge clock);
    #1;
    check_all("reset");

    // Sequential fetch with a two-cycle stall after the first instruction
    reset = 1'b1;
    step("fetch0");
    chk("fetch0.const", ifid_instr, 32'h01098020);
    stall = 1;
    step("stall1");
    step("stall2");
    chk("stall.pc", imem_addr, 32'd1);
    chk("stall.instr", ifid_instr, 32'h01098020);
    stall = 0;
    step("fetch1");
    chk("fetch1.const", ifid_instr, 32'h01098022);
    step("fetch2");
    chk("fetch2.pc4", ifid_pc_plus4, 32'd12);

    // Taken branch backwards to 0
    branch_taken = 1; redirect_pc_plus4 = 32'd8; branch_offset = 16'hFFFE;
    step("branch");
    chk("branch.pc", imem_addr, 32'd0);
    idle_inputs();
    step("branch_tgt");
    chk("branch_tgt.instr", ifid_instr, 32'h01098020);

    // Jump beats stall and a simultaneous branch
    jump = 1; stall = 1; branch_taken = 1; branch_offset = 16'h0040;
    redirect_pc_plus4 = 32'hF000_0010; jump_index = 26'h3;
    step("jump");
    chk("jump.pc", imem_addr, 32'hF000_000C >> 2);
    idle_inputs();
    step("after_jump");

    // Asynchronous reset between edges
    #3;
    reset = 1'b0;
    model_reset();
    #1;
    check_all("async_rst");
    @(posedge clock);
    #1;
    reset = 1'b1;
    step("post_rst");

    // Branch target wraps past 2^32
    branch_taken = 1; redirect_pc_plus4 = 32'hFFFF_FFFC; branch_offset = 16'h0001;
    step("wrap");
    chk("wrap.pc", imem_addr, 32'd0);
    idle_inputs();

    // Random traffic with aligned redirect sources
    for (int n = 0; n < 300; n++) begin
      stall        = ($urandom_range(0, 3) == 0);
      branch_taken = ($urandom_range(0, 7) == 0);
      jump         = ($urandom_range(0, 11) == 0);
      r = $urandom;
      branch_offset = r[15:0];
      r = $urandom;
      jump_index = r[25:0];
      r = $urandom;
      redirect_pc_plus4 = {r[31:2], 2'b00};
      step("rand");
    end
    idle_inputs();

    // Misaligned redirect source
    branch_taken = 1; redirect_pc_plus4 = 32'h0000_0006; branch_offset = 16'h0000;
    step("misalign");
    chk("misalign.valid", {31'b0, ifid_valid}, 32'd0);
    idle_inputs();
    step("misalign_next");
    step("misalign_next2");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
